// File: rtl/mips_dbg_pkg.sv
// Shared constants for the MIPS debug readout blocks: datapath widths,
// register count (shared with the register file) and dump FSM state codes.
package mips_dbg_pkg;

  localparam int DBG_DATA_W   = 32;
  localparam int DBG_ADDR_W   = 5;
  localparam int DBG_NUM_REGS = 32;

  // Dump engine states, kept as plain 2-bit constants so older tools and
  // hand-written waveform decoders can share the encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: on start, freezes architectural writes and
// walks every register through one read port, streaming (index, value)
// words out over a valid/ready interface, then pulses done.
module regfile_dump_reader
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W   = DBG_DATA_W,
  parameter int ADDR_W   = DBG_ADDR_W,
  parameter int NUM_REGS = DBG_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              freeze,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  // Terminal index: the walk stops on this compare rather than on counter overflow,
  // so NUM_REGS below 2**ADDR_W works without wrapping.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              out_valid_reg, out_valid_next;
  logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic              freeze_reg, freeze_next;
  logic              active;

  assign active    = (state_reg == ST_READ) || (state_reg == ST_SEND);
  assign busy      = active;
  assign done      = (state_reg == ST_DONE);
  assign freeze    = freeze_reg;
  assign ra        = active ? idx_reg : '0;
  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;

  // Next-state logic: FSM sequencing, index walk and output word capture/release.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_READ;
          idx_next   = '0;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          out_data_next  = rd;
          out_addr_next  = idx_reg;
          out_valid_next = 1'b1;
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        // Abort wins over a handshake landing on the same edge.
        if (abort) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end else if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          if (idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // Freeze follows the state being entered so it is a clean register output
    // that is high from the first cycle after start is accepted.
    freeze_next = (state_next == ST_READ) || (state_next == ST_SEND);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      freeze_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
      freeze_reg    <= freeze_next;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader. A behavioural register file
// sits on the read port with its write enable gated by freeze; expected words
// come from a snapshot of what the register file must hold when a dump starts.
module tb_regfile_dump_reader;
  import mips_dbg_pkg::*;

  localparam int DW = DBG_DATA_W;
  localparam int AW = DBG_ADDR_W;
  localparam int NR = DBG_NUM_REGS;

  logic          clk = 1'b0;
  logic          reset, start, abort, out_ready;
  logic [AW-1:0] ra, out_addr;
  logic [DW-1:0] rd, out_data;
  logic          freeze, busy, done, out_valid;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;

  logic [DW-1:0] rf   [NR];
  logic [DW-1:0] snap [NR];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ra(ra), .rd(rd), .freeze(freeze), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  // Register file: combinational read, core write gated by freeze.
  assign rd = rf[ra];
  always_ff @(posedge clk) begin
    if (we3 && !freeze) rf[wa3] <= wd3;
  end

  // Advance one cycle; the bench observes and drives at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fill the register file through the core write port and record the snapshot.
  task automatic preload(input bit rnd);
    for (int i = 0; i < NR; i++) begin
      we3 = 1'b1;
      wa3 = AW'(i);
      wd3 = rnd ? DW'($urandom) : DW'(i) * 32'h0101_0101;
      snap[i] = wd3;
      tick();
    end
    we3 = 1'b0;
  endtask

  // Generic dump against the snapshot with random backpressure.
  task automatic run_dump(input int pct);
    int exp_idx;
    bit fin;
    exp_idx = 0;
    fin = 1'b0;
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    n_cmp++;
    if (!(busy && freeze)) begin
      n_bad++; $display("FAIL dump_begin busy=%0b freeze=%0b want 1 1", busy, freeze);
    end
    for (int c = 1; c < 4000 && !fin; c++) begin
      if (done) begin
        n_cmp++;
        if (exp_idx != NR) begin
          n_bad++; $display("FAIL dump_done_count got %0d words want %0d", exp_idx, NR);
        end
        fin = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 99) < pct);
        if (out_valid) begin
          n_cmp++;
          if (exp_idx >= NR || out_addr !== AW'(exp_idx) || out_data !== snap[exp_idx % NR]) begin
            n_bad++;
            $display("FAIL dump_word got %0d:%08h want %0d:%08h", out_addr, out_data,
                     exp_idx, snap[exp_idx % NR]);
          end
          if (out_ready) begin
            $display("word %0d = %08h", out_addr, out_data);
            exp_idx++;
          end
        end
        tick();
      end
    end
    if (!fin) begin
      n_cmp++; n_bad++; $display("FAIL dump_timeout got %0d words want done", exp_idx);
    end
    out_ready = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL dump_idle busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    we3 = 1'b0; wa3 = '0; wd3 = '0;
    repeat (3) tick();
    n_cmp++;
    if ({ra, freeze, busy, done, out_valid, out_addr, out_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs ra=%0d fr=%0b bz=%0b dn=%0b v=%0b a=%0d d=%08h want all 0",
               ra, freeze, busy, done, out_valid, out_addr, out_data);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle busy=%0b valid=%0b want 0 0", busy, out_valid);
    end
  endtask

  // Exact cycle timing with out_ready held high.
  task automatic test_full_dump();
    bit eb, ev, ed;
    int k;
    preload(1'b0);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      eb = (c <= 64);
      ev = (c >= 2) && (c <= 64) && (c % 2 == 0);
      ed = (c == 65);
      n_cmp++;
      if ({busy, freeze, done, out_valid} !== {eb, eb, ed, ev}) begin
        n_bad++;
        $display("FAIL full_ctrl c=%0d got b/f/d/v=%b want %b", c,
                 {busy, freeze, done, out_valid}, {eb, eb, ed, ev});
      end
      if (eb) begin
        n_cmp++;
        if (ra !== AW'((c - 1) / 2)) begin
          n_bad++; $display("FAIL full_ra c=%0d got %0d want %0d", c, ra, (c - 1) / 2);
        end
      end
      if (ev) begin
        k = (c - 2) / 2;
        n_cmp++;
        if (out_addr !== AW'(k) || out_data !== snap[k]) begin
          n_bad++;
          $display("FAIL full_word c=%0d got %0d:%08h want %0d:%08h", c, out_addr, out_data, k, snap[k]);
        end
      end
      tick();
    end
  endtask

  // Five stalled cycles on word 3; word 4 two cycles after ready returns.
  task automatic test_backpressure();
    bit fin;
    fin = 1'b0;
    preload(1'b1);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 90 && !fin; c++) begin
      out_ready = !(c >= 8 && c <= 12);
      if (c >= 8 && c <= 13) begin
        n_cmp++;
        if (!out_valid || out_addr !== AW'(3) || out_data !== snap[3]) begin
          n_bad++;
          $display("FAIL bp_hold c=%0d got v=%0b %0d:%08h want 1 3:%08h", c, out_valid, out_addr, out_data, snap[3]);
        end
      end
      if (c == 14) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++; $display("FAIL bp_gap got valid=%0b want 0", out_valid);
        end
      end
      if (c == 15) begin
        n_cmp++;
        if (!out_valid || out_addr !== AW'(4) || out_data !== snap[4]) begin
          n_bad++;
          $display("FAIL bp_next got v=%0b %0d:%08h want 1 4:%08h", out_valid, out_addr, out_data, snap[4]);
        end
      end
      if (done) begin
        fin = 1'b1;
        n_cmp++;
        if (c != 70) begin
          n_bad++; $display("FAIL bp_done_cycle got %0d want 70", c);
        end
      end
      tick();
    end
    if (!fin) begin
      n_cmp++; n_bad++; $display("FAIL bp_timeout got no done want done at 70");
    end
    out_ready = 1'b0;
  endtask

  // Write at the start edge lands; writes during the dump are held off.
  task automatic test_write_gating();
    bit fin, seen5, seen7;
    logic [DW-1:0] pre7;
    fin = 1'b0; seen5 = 1'b0; seen7 = 1'b0;
    preload(1'b1);
    pre7 = snap[7];
    start = 1'b1; out_ready = 1'b1;
    we3 = 1'b1; wa3 = AW'(5); wd3 = 32'h5A5A_0005;
    snap[5] = wd3;
    tick();
    start = 1'b0;
    wa3 = AW'(7); wd3 = 32'hDEAD_BEEF;
    for (int c = 1; c <= 80 && !fin; c++) begin
      if (out_valid && out_addr == AW'(5)) begin
        seen5 = 1'b1;
        n_cmp++;
        if (out_data !== snap[5]) begin
          n_bad++; $display("FAIL wg_start_write got %08h want %08h", out_data, snap[5]);
        end
      end
      if (out_valid && out_addr == AW'(7)) begin
        seen7 = 1'b1;
        n_cmp++;
        if (out_data !== pre7) begin
          n_bad++; $display("FAIL wg_frozen got %08h want %08h", out_data, pre7);
        end
      end
      if (done) fin = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!(fin && seen5 && seen7)) begin
      n_bad++; $display("FAIL wg_progress got done=%0b w5=%0b w7=%0b want 1 1 1", fin, seen5, seen7);
    end
    tick();
    we3 = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (rf[7] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL wg_after_done got %08h want deadbeef", rf[7]);
    end
    snap[7] = 32'hDEAD_BEEF;
  endtask

  // Abort on word 10 with a same-cycle handshake.
  task automatic test_abort();
    int acc;
    bit hit;
    acc = 0; hit = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 30 && !hit; c++) begin
      if (c == 22) begin
        n_cmp++;
        if (!out_valid || out_addr !== AW'(10)) begin
          n_bad++; $display("FAIL abort_word got v=%0b a=%0d want 1 10", out_valid, out_addr);
        end
        abort = 1'b1;
      end else if (c == 23) begin
        hit = 1'b1;
        n_cmp++;
        if ({out_valid, freeze, busy, done} !== 4'b0000) begin
          n_bad++; $display("FAIL abort_idle got v/f/b/d=%b want 0000", {out_valid, freeze, busy, done});
        end
      end else if (out_valid && out_ready) begin
        acc++;
      end
      if (!hit) tick();
    end
    abort = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (acc != 10 || !hit) begin
      n_bad++; $display("FAIL abort_accepted got %0d want 10", acc);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL abort_no_done got d=%0b b=%0b want 0 0", done, busy);
      end
    end
  endtask

  // Reset during word 20, then a fresh dump from index 0.
  task automatic test_reset_mid();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      if (c == 42) begin
        n_cmp++;
        if (!out_valid || out_addr !== AW'(20)) begin
          n_bad++; $display("FAIL rmid_word got v=%0b a=%0d want 1 20", out_valid, out_addr);
        end
        reset = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if ({ra, freeze, busy, done, out_valid, out_addr, out_data} !== '0) begin
      n_bad++;
      $display("FAIL rmid_outputs ra=%0d fr=%0b bz=%0b dn=%0b v=%0b a=%0d d=%08h want all 0",
               ra, freeze, busy, done, out_valid, out_addr, out_data);
    end
    tick();
    run_dump(60);
  endtask

  // Held start gives one dump, then a second starts right after IDLE.
  task automatic test_start_held();
    int dones;
    dones = 0;
    start = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (done) dones++;
      if (c == 66) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++; $display("FAIL held_idle got busy=%0b want 0", busy);
        end
      end
      if (c == 67) begin
        n_cmp++;
        if (busy !== 1'b1 || ra !== '0) begin
          n_bad++; $display("FAIL held_restart got busy=%0b ra=%0d want 1 0", busy, ra);
        end
      end
      if (c == 68) begin
        n_cmp++;
        if (!out_valid || out_addr !== '0 || out_data !== snap[0]) begin
          n_bad++;
          $display("FAIL held_word0 got v=%0b %0d:%08h want 1 0:%08h", out_valid, out_addr, out_data, snap[0]);
        end
      end
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (dones != 1) begin
      n_bad++; $display("FAIL held_done_count got %0d want 1", dones);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || freeze !== 1'b0) begin
      n_bad++; $display("FAIL held_abort got busy=%0b freeze=%0b want 0 0", busy, freeze);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_write_gating();
    test_abort();
    test_reset_mid();
    test_start_held();
    preload(1'b1);
    run_dump(35);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/readout engine for the 32x32 MIPS register file.
- On a start pulse it freezes architectural writes and reads every register in turn through one register-file read port.
- Each value is streamed out as an (address, data) word on a valid/ready interface.
- Sits beside the register file; the top level muxes its `ra` onto one read-address port and ANDs the core's write enable with `~freeze`.

Parameters:
- DATA_W, 32, register width and out_data width.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1); must be <= 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a full dump; sampled only in IDLE.
- abort  in  1  cancel a dump in progress; sampled in READ/SEND.
- ra  out  ADDR_W  read address driven to the register-file read port.
- rd  in  DATA_W  combinational read data returned for ra (same cycle).
- freeze  out  1  high while dumping; gates the core's register write enable.
- busy  out  1  high in READ and SEND.
- done  out  1  one-cycle pulse after the last word is accepted.
- out_valid  out  1  out_addr/out_data hold a word.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_addr  out  ADDR_W  register index of the current word.
- out_data  out  DATA_W  register contents of the current word.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, idx=0.
  - ra=0, freeze=0, busy=0, done=0, out_valid=0, out_addr=0, out_data=0.
  - Reset asserted mid-dump returns to IDLE next edge; no done pulse is produced.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - ra=0.
  - start=1 -> READ, idx=0.
  - start while not IDLE is ignored (not queued).
- READ:
  - ra=idx, freeze=1, busy=1.
  - At the edge, capture out_data<=rd, out_addr<=idx, out_valid<=1 -> SEND.
- SEND:
  - ra=idx, freeze=1, busy=1.
  - out_valid, out_addr and out_data are held stable until the handshake.
  - On handshake (out_valid & out_ready), out_valid<=0:
    - if idx==NUM_REGS-1 -> DONE;
    - else idx<=idx+1 -> READ.
- DONE:
  - done=1 for exactly one cycle; busy=0, freeze=0 -> IDLE.
- abort=1 in READ or SEND:
  - next edge -> IDLE, out_valid<=0, freeze<=0, no done pulse.
  - Abort takes priority over a simultaneous handshake.
  - This is the only case where out_valid drops without a handshake.
- Timing, with start high in cycle 0 and out_ready held high:
  - busy/freeze rise in cycle 1.
  - Word k is valid in cycle 2+2k.
  - The last word (k=31) is valid in cycle 64.
  - done pulses in cycle 65; IDLE from cycle 66.
  - Backpressure stretches SEND with no data change.
- Consistency guarantee:
  - freeze is registered and is high from the cycle after start is accepted.
  - Every dumped value therefore reflects register-file state after any write committed at the start edge.
- idx width is ADDR_W; no wrap beyond NUM_REGS-1 (terminal compare, not overflow).
- Register 0 is dumped like any other; its value is whatever rd returns.

Decomposition:
- Shared package `mips_dbg_pkg`:
  - state enum (IDLE/READ/SEND/DONE);
  - DATA_W and ADDR_W defaults;
  - NUM_REGS constant (shared with the register file).
- No sub-module needed: the FSM, index counter and output register fit in one module.
- Bench reuses the existing register file as the read target.

Test Plan:
- Preload rf[i]=i*0x01010101; pulse start with out_ready=1 -> 32 words (i, i*0x01010101) in cycles 2,4,...,64; done=1 only in cycle 65.
- out_ready=0 for 5 cycles while word 3 is valid -> out_addr=3 and out_data stay constant; word 4 follows 2 cycles after ready rises.
- Core drives we3=1, wa3=7, wd3=0xDEADBEEF while freeze=1 (write gated) -> dumped word 7 equals the preload value; after done the write is accepted normally.
- abort=1 while in SEND for word 10 (out_ready=1 same cycle) -> IDLE next cycle, out_valid=0, freeze=0, no done pulse, word 10 not counted as accepted.
- reset=1 for one cycle during word 20 -> all outputs 0 next cycle; a new start then dumps again from index 0.
- start held high for 100 cycles -> exactly one dump (done once), then a second dump begins the cycle after return to IDLE.
